// File: rtl/serial_byte_receiver.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit frames delivered MSB- or LSB-first
// into a one-entry valid/ready output buffer, with sticky overrun and frame-abort flags.
module serial_byte_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             start_bit;
    logic             data_bit;
    logic             last_bit;
    logic             dir_eff;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;

    // A start bit always opens a fresh frame, even mid-frame, so it sees a cleared
    // register and the newly presented bit order.
    assign start_bit  = sin_valid && start;
    assign data_bit   = sin_valid && !start && (state_q == RECV);
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    assign dir_eff    = start_bit ? dir : dir_q;
    assign shift_base = start_bit ? '0 : shreg_q;
    assign shifted    = dir_eff ? {sin, shift_base[WIDTH-1:1]}
                                : {shift_base[WIDTH-2:0], sin};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb output is given a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_bit) state_d = RECV;
            RECV:    if (data_bit && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RECV);
    end

    always_comb begin
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dir_d        = dir_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = frame_err_q;

        if (clr_err) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Set conditions come after the clear so a coincident event wins.
        if (start_bit) begin
            dir_d   = dir;
            shreg_d = shifted;
            cnt_d   = CW'(1);
            if (state_q == RECV) begin
                frame_err_d = 1'b1;
            end
        end else if (data_bit) begin
            shreg_d = shifted;
            if (last_bit) begin
                cnt_d = '0;
                if (!dout_valid_q || dout_ready) begin
                    dout_d       = shifted;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            shreg_q      <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed self-checking bench for serial_byte_receiver (WIDTH = 8).
module tb_serial_byte_receiver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clr_err = 1'b0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    serial_byte_receiver #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .start      (start),
        .dir        (dir),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic send_bit(input logic b, input logic st, input logic d,
                            input logic rdy, input logic clr);
        @(negedge clk);
        sin        = b;
        sin_valid  = 1'b1;
        start      = st;
        dir        = d;
        dout_ready = rdy;
        clr_err    = clr;
        @(posedge clk);
        #1;
        sin_valid  = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;
        clr_err    = 1'b0;
    endtask

    task automatic idle_cycle(input logic rdy, input logic clr);
        @(negedge clk);
        dout_ready = rdy;
        clr_err    = clr;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        clr_err    = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] word, input logic d,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(d ? word[i] : word[WIDTH-1-i], i == 0, d,
                     (i == WIDTH - 1) && rdy_last, (i == WIDTH - 1) && clr_last);
        end
    endtask

    initial begin
        logic [7:0] msb_bits;
        logic [7:0] lsb_bits;

        // Reset state
        #12;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // MSB-first frame 1,0,1,1,0,0,1,0 -> 0xB2
        msb_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            send_bit(msb_bits[7-i], i == 0, 1'b0, 1'b0, 1'b0);
            if (i == 0) check("msb_busy_first", busy, 1'b1);
            if (i == 6) check("msb_valid_before_last", dout_valid, 1'b0);
        end
        check("msb_dout", dout, 8'hB2);
        check("msb_valid", dout_valid, 1'b1);
        check("msb_busy_done", busy, 1'b0);
        check("msb_overrun", overrun, 1'b0);
        check("msb_frame_err", frame_err, 1'b0);
        idle_cycle(1'b1, 1'b0);
        check("consume_valid", dout_valid, 1'b0);
        check("consume_dout_held", dout, 8'hB2);

        // Ignored data while idle
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ignore_busy", busy, 1'b0);
        check("ignore_valid", dout_valid, 1'b0);
        check("ignore_dout", dout, 8'hB2);

        // LSB-first frame 0,1,0,0,1,1,0,1 with a 3-cycle stall; dir toggles mid-frame
        lsb_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            send_bit(lsb_bits[i], i == 0, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                for (int s = 0; s < 3; s++) idle_cycle(1'b0, 1'b0);
                check("lsb_stall_busy", busy, 1'b1);
                check("lsb_stall_valid", dout_valid, 1'b0);
            end
        end
        check("lsb_dout", dout, 8'hB2);
        check("lsb_valid", dout_valid, 1'b1);
        check("lsb_busy_done", busy, 1'b0);
        idle_cycle(1'b1, 1'b0);

        // Overrun, then completion with simultaneous consume
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        check("ovr_first_dout", dout, 8'h5A);
        check("ovr_first_valid", dout_valid, 1'b1);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        check("ovr_dout_kept", dout, 8'h5A);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid_kept", dout_valid, 1'b1);
        idle_cycle(1'b0, 1'b1);
        check("ovr_cleared", overrun, 1'b0);
        check("ovr_valid_after_clr", dout_valid, 1'b1);
        send_word(8'h0F, 1'b0, 1'b1, 1'b0);
        check("swap_dout", dout, 8'h0F);
        check("swap_valid", dout_valid, 1'b1);
        check("swap_no_overrun", overrun, 1'b0);
        idle_cycle(1'b1, 1'b0);
        check("swap_consumed", dout_valid, 1'b0);

        // Abort after 4 bits, restart frame 0x96 MSB-first
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b0, 1'b0, 1'b0);
        check("abort_no_err_yet", frame_err, 1'b0);
        msb_bits = 8'h96;
        send_bit(msb_bits[7], 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_frame_err", frame_err, 1'b1);
        check("abort_busy", busy, 1'b1);
        for (int i = 6; i >= 1; i--) send_bit(msb_bits[i], 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_not_done", dout_valid, 1'b0);
        send_bit(msb_bits[0], 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_dout", dout, 8'h96);
        check("abort_valid", dout_valid, 1'b1);
        check("abort_err_sticky", frame_err, 1'b1);
        idle_cycle(1'b1, 1'b1);
        check("abort_err_cleared", frame_err, 1'b0);

        // Asynchronous reset mid-frame with 0xFF pending
        send_word(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1, i == 0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_dout", dout, 8'hFF);
        check("pre_rst_busy", busy, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_dout", dout, 8'h00);
        check("async_rst_valid", dout_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        #1;
        reset = 1'b0;
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        check("post_rst_dout", dout, 8'h81);
        check("post_rst_valid", dout_valid, 1'b1);

        // Overrun set wins over a coincident clr_err
        send_word(8'h00, 1'b0, 1'b0, 1'b1);
        check("setwins_overrun", overrun, 1'b1);
        check("setwins_dout", dout, 8'h81);
        idle_cycle(1'b0, 1'b1);
        check("setwins_cleared", overrun, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Serial-to-parallel receiver; the receiving end of the serial stream produced by the bidirectional shift register when it runs in shift mode.
- Collects WIDTH serially delivered bits per frame in MSB-first or LSB-first order and rebuilds the parallel word.
- Holds the word in a one-entry output buffer with a valid/ready handshake.
- Reports overrun and aborted frames through sticky flags.

Parameters:
- WIDTH, 8, bits per frame and width of dout. Must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a valid bit this cycle.
- start  input  1  qualified by sin_valid: this bit is bit 0 of a new frame.
- dir  input  1  bit order, sampled only on a start bit. 0 = MSB first (matches left-shift transmit from the MSB). 1 = LSB first (matches right-shift transmit from the LSB).
- dout  output  WIDTH  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  a frame is in progress.
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- frame_err  output  1  sticky: a frame was aborted by a new start before it completed.
- clr_err  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset, asynchronous: state IDLE, bit counter 0, shift register 0, dout 0, dout_valid 0, busy 0, overrun 0, frame_err 0, latched dir 0.
- State IDLE:
  - sin_valid=1 with start=1: latch dir, shift in sin as bit 0, counter=1, go to RECV.
  - sin_valid=1 with start=0: ignored.
- State RECV:
  - Each sin_valid=1 with start=0 shifts sin in and increments the counter.
  - Cycles with sin_valid=0 hold all state. Stall length is unbounded.
- Shift direction:
  - Latched dir=0: shreg <= {shreg[WIDTH-2:0], sin}. The first bit ends in dout[WIDTH-1].
  - Latched dir=1: shreg <= {sin, shreg[WIDTH-1:1]}. The first bit ends in dout[0].
- Frame completion:
  - On the edge that accepts bit WIDTH-1, the assembled word (including that bit) is the completed word.
  - FSM returns to IDLE and the counter clears.
  - Latency: dout and dout_valid update on that same edge. Valid is visible the cycle after the last bit is presented.
- Output buffer, rules evaluated per edge:
  - dout_valid=1 and dout_ready=1: consume. dout_valid drops unless a word completes on the same edge.
  - Word completes and buffer is empty or being consumed on that edge: load dout, dout_valid=1.
  - Word completes, dout_valid=1 and dout_ready=0: word dropped, dout unchanged, overrun<=1.
  - dout holds its value after consumption until the next load.
- Start in RECV: a sin_valid=1 with start=1 aborts the partial frame. Set frame_err, discard partial bits, treat this bit as bit 0 of a new frame (re-latch dir, counter=1).
- Changes to dir in the middle of a frame have no effect.
- busy = (state == RECV).
- clr_err=1 clears both sticky flags. If a set condition occurs on the same edge, the set wins.
- WIDTH=8 frame length is exactly 8 accepted bits. No stop bit, no parity.
- Asserting reset mid-frame or with dout_valid=1 discards everything and returns all outputs to their reset values immediately, without waiting for clk.

Test Plan:
- MSB-first frame: dir=0, start on first bit, bits 1,0,1,1,0,0,1,0 on consecutive cycles, dout_ready=0 -> after the 8th edge dout=8'hB2, dout_valid=1, busy=0, no flags set.
- LSB-first frame with stalls: dir=1, bits 0,1,0,0,1,1,0,1 (first to last) with sin_valid low for 3 cycles between bits 3 and 4 -> dout=8'hB2 and dout_valid=1 only after the 8th valid bit; busy stays 1 through the stall.
- Overrun and simultaneous consume:
  - Receive 8'h5A and leave it unconsumed, then receive 8'hC3 -> dout stays 8'h5A, overrun=1.
  - Next frame 8'h0F with dout_ready=1 on its completing edge -> dout=8'h0F, dout_valid stays 1, no new overrun.
- Abort:
  - Start a frame, send 4 bits, then assert start with a new bit -> frame_err=1, counter restarts.
  - The following 7 bits complete a correct 8-bit word from the restart point.
  - clr_err -> frame_err=0.
- Reset mid-frame: after 5 bits with dout_valid=1 holding 8'hFF, assert reset between clock edges -> dout=0, dout_valid=0, busy=0 immediately. A subsequent full frame 8'h81 is received correctly.
- Ignored data: sin_valid pulses with start=0 while IDLE -> no state change, busy=0, dout_valid unchanged.
